// File: rtl/pixel_pos_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pixel_pos_pkg
// Brief    : Shared types, RGB565 field slices and default colour thresholds
//            for the camera pixel position front end.
// Revision : 1.0 - initial release
// ============================================================================
package pixel_pos_pkg;

    typedef enum logic [1:0] {
        SYNC_WAIT = 2'd0,
        VBLANK    = 2'd1,
        ACTIVE    = 2'd2
    } state_t;

    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

    localparam logic [4:0] DEF_PINK_R_MIN  = 5'd20;
    localparam logic [5:0] DEF_PINK_G_MAX  = 6'd24;
    localparam logic [4:0] DEF_PINK_B_MIN  = 5'd12;
    localparam logic [5:0] DEF_GREEN_G_MIN = 6'd40;
    localparam logic [4:0] DEF_GREEN_R_MAX = 5'd12;
    localparam logic [4:0] DEF_GREEN_B_MAX = 5'd12;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/color_classify.sv
`default_nettype none
// ============================================================================
// Module   : color_classify
// Brief    : Combinational RGB565 pink/green classifier. Green detection is
//            only built when GREEN_DETECT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module color_classify
    import pixel_pos_pkg::*;
#(
    parameter logic [4:0] PINK_R_MIN  = DEF_PINK_R_MIN,
    parameter logic [5:0] PINK_G_MAX  = DEF_PINK_G_MAX,
    parameter logic [4:0] PINK_B_MIN  = DEF_PINK_B_MIN
`ifdef GREEN_DETECT_EN
    ,
    parameter logic [5:0] GREEN_G_MIN = DEF_GREEN_G_MIN,
    parameter logic [4:0] GREEN_R_MAX = DEF_GREEN_R_MAX,
    parameter logic [4:0] GREEN_B_MAX = DEF_GREEN_B_MAX
`endif
) (
    input  logic [15:0] pixel,
    output logic        pink
`ifdef GREEN_DETECT_EN
    ,
    output logic        green
`endif
);

    logic [4:0] r5;
    logic [5:0] g6;
    logic [4:0] b5;

    assign r5 = pixel[R_MSB:R_LSB];
    assign g6 = pixel[G_MSB:G_LSB];
    assign b5 = pixel[B_MSB:B_LSB];

    assign pink = (r5 >= PINK_R_MIN) && (g6 <= PINK_G_MAX) && (b5 >= PINK_B_MIN);

`ifdef GREEN_DETECT_EN
    assign green = (g6 >= GREEN_G_MIN) && (r5 <= GREEN_R_MAX) && (b5 <= GREEN_B_MAX);
`endif

endmodule
`default_nettype wire

// File: rtl/pixel_pos_gen.sv
`default_nettype none
// ============================================================================
// Module   : pixel_pos_gen
// Brief    : Decodes a vsync/href RGB565 byte stream into per-pixel x/y
//            coordinates with pink/green classification. Macro
//            GREEN_DETECT_EN enables the green classifier output.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_pos_gen
    import pixel_pos_pkg::*;
#(
    parameter int         H_ACTIVE    = 640,
    parameter int         V_ACTIVE    = 480,
    parameter logic [4:0] PINK_R_MIN  = DEF_PINK_R_MIN,
    parameter logic [5:0] PINK_G_MAX  = DEF_PINK_G_MAX,
    parameter logic [4:0] PINK_B_MIN  = DEF_PINK_B_MIN
`ifdef GREEN_DETECT_EN
    ,
    parameter logic [5:0] GREEN_G_MIN = DEF_GREEN_G_MIN,
    parameter logic [4:0] GREEN_R_MAX = DEF_GREEN_R_MAX,
    parameter logic [4:0] GREEN_B_MAX = DEF_GREEN_B_MAX
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    output logic [15:0] x_pos,
    output logic [15:0] y_pos,
    output logic        pix_valid,
    output logic        binary_pink,
    output logic        binary_green,
    output logic        new_frame,
    output logic        frame_err
);

    localparam logic [15:0] H_MAX = 16'(H_ACTIVE);
    localparam logic [15:0] V_MAX = 16'(V_ACTIVE);

    state_t      state;
    logic        vs_q, hr_q, vs_prev, hr_prev;
    logic [7:0]  d_q;
    logic [7:0]  first_byte;
    logic        phase;
    logic        err;
    logic [15:0] x_cnt, y_cnt;

    logic        vs_rise, vs_fall, hr_fall;
    logic [15:0] pixel;
    logic        pink_w;

    assign vs_rise = vs_q & ~vs_prev;
    assign vs_fall = ~vs_q & vs_prev;
    assign hr_fall = ~hr_q & hr_prev;
    assign pixel   = {first_byte, d_q};

`ifdef GREEN_DETECT_EN
    logic green_w;

    color_classify #(
        .PINK_R_MIN  (PINK_R_MIN),
        .PINK_G_MAX  (PINK_G_MAX),
        .PINK_B_MIN  (PINK_B_MIN),
        .GREEN_G_MIN (GREEN_G_MIN),
        .GREEN_R_MAX (GREEN_R_MAX),
        .GREEN_B_MAX (GREEN_B_MAX)
    ) u_classify (
        .pixel (pixel),
        .pink  (pink_w),
        .green (green_w)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            binary_green <= 1'b0;
        end else begin
            binary_green <= (state == ACTIVE) && !vs_rise && !hr_fall && hr_q && phase
                            && (x_cnt < H_MAX) && (y_cnt < V_MAX) && green_w;
        end
    end
`else
    color_classify #(
        .PINK_R_MIN (PINK_R_MIN),
        .PINK_G_MAX (PINK_G_MAX),
        .PINK_B_MIN (PINK_B_MIN)
    ) u_classify (
        .pixel (pixel),
        .pink  (pink_w)
    );

    assign binary_green = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= SYNC_WAIT;
            vs_q        <= 1'b0;
            hr_q        <= 1'b0;
            vs_prev     <= 1'b0;
            hr_prev     <= 1'b0;
            d_q         <= 8'd0;
            first_byte  <= 8'd0;
            phase       <= 1'b0;
            err         <= 1'b0;
            x_cnt       <= 16'd0;
            y_cnt       <= 16'd0;
            x_pos       <= 16'd0;
            y_pos       <= 16'd0;
            pix_valid   <= 1'b0;
            binary_pink <= 1'b0;
            new_frame   <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            vs_q        <= cam_vsync;
            hr_q        <= cam_href;
            d_q         <= cam_data;
            vs_prev     <= vs_q;
            hr_prev     <= hr_q;
            pix_valid   <= 1'b0;
            binary_pink <= 1'b0;
            new_frame   <= 1'b0;
            frame_err   <= 1'b0;

            case (state)
                SYNC_WAIT: begin
                    if (vs_rise) begin
                        new_frame <= 1'b1;
                        x_cnt     <= 16'd0;
                        y_cnt     <= 16'd0;
                        phase     <= 1'b0;
                        err       <= 1'b0;
                        state     <= VBLANK;
                    end
                end
                VBLANK: begin
                    if (vs_rise) begin
                        new_frame <= 1'b1;
                        x_cnt     <= 16'd0;
                        y_cnt     <= 16'd0;
                        phase     <= 1'b0;
                        err       <= 1'b0;
                    end else if (vs_fall) begin
                        state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    // A vsync rise with href still high aborts the line without counting it.
                    if (vs_rise) begin
                        new_frame <= 1'b1;
                        frame_err <= hr_q || err || (y_cnt != V_MAX);
                        x_cnt     <= 16'd0;
                        y_cnt     <= 16'd0;
                        phase     <= 1'b0;
                        err       <= 1'b0;
                        state     <= VBLANK;
                    end else if (hr_fall) begin
                        if (phase || (x_cnt != H_MAX) || (y_cnt == CNT_MAX)) begin
                            err <= 1'b1;
                        end
                        if (x_cnt != 16'd0) begin
                            y_cnt <= sat_inc(y_cnt);
                        end
                        x_cnt <= 16'd0;
                        phase <= 1'b0;
                    end else if (hr_q) begin
                        phase <= ~phase;
                        if (!phase) begin
                            first_byte <= d_q;
                        end else if ((x_cnt < H_MAX) && (y_cnt < V_MAX)) begin
                            pix_valid   <= 1'b1;
                            binary_pink <= pink_w;
                            x_pos       <= x_cnt;
                            y_pos       <= y_cnt;
                            x_cnt       <= sat_inc(x_cnt);
                            if (x_cnt == CNT_MAX) begin
                                err <= 1'b1;
                            end
                        end else if (x_cnt >= H_MAX) begin
                            err <= 1'b1;
                        end
                    end
                end
                default: state <= SYNC_WAIT;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pixel_pos_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_pos_gen
// Brief    : Directed self-checking bench for pixel_pos_gen on a 4x3 frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_pos_gen;

    localparam int H = 4;
    localparam int V = 3;
`ifdef GREEN_DETECT_EN
    localparam logic GREEN_ON = 1'b1;
`else
    localparam logic GREEN_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cam_vsync;
    logic        cam_href;
    logic [7:0]  cam_data;
    logic [15:0] x_pos, y_pos;
    logic        pix_valid, binary_pink, binary_green, new_frame, frame_err;

    int checks = 0;
    int errors = 0;

    int          px_n = 0, nf_cnt = 0, fe_cnt = 0, both_cnt = 0;
    logic [15:0] px_x [256];
    logic [15:0] px_y [256];
    logic        px_pink [256];
    logic        px_green [256];

    logic [15:0] base_pix    = 16'hF81F;
    logic [15:0] special_pix = 16'h07E0;
    int          special_x   = -1;
    int          special_y   = -1;

    pixel_pos_gen #(
        .H_ACTIVE (H),
        .V_ACTIVE (V)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cam_vsync    (cam_vsync),
        .cam_href     (cam_href),
        .cam_data     (cam_data),
        .x_pos        (x_pos),
        .y_pos        (y_pos),
        .pix_valid    (pix_valid),
        .binary_pink  (binary_pink),
        .binary_green (binary_green),
        .new_frame    (new_frame),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pix_valid && px_n < 256) begin
            px_x[px_n]     = x_pos;
            px_y[px_n]     = y_pos;
            px_pink[px_n]  = binary_pink;
            px_green[px_n] = binary_green;
            px_n++;
        end
        if (new_frame) nf_cnt++;
        if (frame_err) fe_cnt++;
        if (new_frame && frame_err) both_cnt++;
    end

    function automatic logic [15:0] pix_of(input int x, input int row);
        return (x == special_x && row == special_y) ? special_pix : base_pix;
    endfunction

    task automatic send_line(input int nbytes, input int row);
        logic [15:0] p;
        for (int i = 0; i < nbytes; i++) begin
            p = pix_of(i / 2, row);
            @(negedge clk);
            cam_href = 1'b1;
            cam_data = (i % 2 == 0) ? p[15:8] : p[7:0];
        end
        @(negedge clk);
        cam_href = 1'b0;
        cam_data = 8'd0;
        repeat (4) @(negedge clk);
    endtask

    task automatic vsync_pulse();
        @(negedge clk);
        cam_vsync = 1'b1;
        repeat (4) @(negedge clk);
        cam_vsync = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_frame_pixels(input string name, input int base);
        logic [33:0] exp_v, got_v;
        logic        sp;
        for (int i = 0; i < H * V; i++) begin
            sp    = ((i % H) == special_x) && ((i / H) == special_y);
            exp_v = {16'(i % H), 16'(i / H), !sp, sp & GREEN_ON};
            got_v = {px_x[base+i], px_y[base+i], px_pink[base+i], px_green[base+i]};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL %s pixel %0d: got x=%0d y=%0d pink=%b green=%b, expected x=%0d y=%0d pink=%b green=%b",
                         name, i, got_v[33:18], got_v[17:2], got_v[1], got_v[0],
                         exp_v[33:18], exp_v[17:2], exp_v[1], exp_v[0]);
            end
        end
    endtask

    task automatic test_reset();
        int base, nf0;
        logic [15:0] p;
        rst = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({x_pos, y_pos, pix_valid, binary_pink, binary_green, new_frame, frame_err} !== 37'd0) begin
            errors++;
            $display("FAIL reset_values: got x=%0d y=%0d v=%b p=%b g=%b nf=%b fe=%b, expected all 0",
                     x_pos, y_pos, pix_valid, binary_pink, binary_green, new_frame, frame_err);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vsync_pulse();
        // Stream a line and assert reset while a pixel is being presented.
        for (int i = 0; i < 6; i++) begin
            p = base_pix;
            @(negedge clk);
            cam_href = 1'b1;
            cam_data = (i % 2 == 0) ? p[15:8] : p[7:0];
        end
        checks++;
        if (pix_valid !== 1'b1 || x_pos !== 16'd1) begin
            errors++;
            $display("FAIL pre_reset_pixel: got valid=%b x=%0d, expected valid=1 x=1", pix_valid, x_pos);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (pix_valid !== 1'b0 || x_pos !== 16'd0 || binary_pink !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got valid=%b x=%0d pink=%b, expected 0 0 0", pix_valid, x_pos, binary_pink);
        end
        base = px_n;
        nf0  = nf_cnt;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        repeat (4) @(negedge clk);
        cam_href = 1'b0;
        repeat (4) @(negedge clk);
        send_line(8, 0);
        send_line(8, 1);
        checks++;
        if (px_n != base || nf_cnt != nf0) begin
            errors++;
            $display("FAIL post_reset_quiet: got pixels=%0d new_frames=%0d, expected 0 0", px_n - base, nf_cnt - nf0);
        end
        vsync_pulse();
        checks++;
        if (px_n != base || nf_cnt != nf0 + 1) begin
            errors++;
            $display("FAIL first_new_frame: got pixels=%0d new_frames=%0d, expected 0 1", px_n - base, nf_cnt - nf0);
        end
    endtask

    task automatic test_frame();
        int base, nf0, fe0;
        logic [15:0] p;
        base = px_n; nf0 = nf_cnt; fe0 = fe_cnt;
        special_x = -1; special_y = -1;
        for (int i = 0; i < 2 * H; i++) begin
            p = base_pix;
            @(negedge clk);
            if (i == 2) begin
                checks++;
                if (pix_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL latency_early: got valid=%b, expected 0", pix_valid);
                end
            end
            if (i == 3) begin
                checks++;
                if (pix_valid !== 1'b1 || x_pos !== 16'd0 || y_pos !== 16'd0) begin
                    errors++;
                    $display("FAIL latency_first: got valid=%b x=%0d y=%0d, expected 1 0 0", pix_valid, x_pos, y_pos);
                end
            end
            cam_href = 1'b1;
            cam_data = (i % 2 == 0) ? p[15:8] : p[7:0];
        end
        @(negedge clk);
        cam_href = 1'b0;
        repeat (4) @(negedge clk);
        send_line(2 * H, 1);
        send_line(2 * H, 2);
        vsync_pulse();
        checks++;
        if (px_n - base != 12) begin
            errors++;
            $display("FAIL frame_count: got %0d pixels, expected 12", px_n - base);
        end
        check_frame_pixels("frame", base);
        checks++;
        if (fe_cnt != fe0 || nf_cnt != nf0 + 1) begin
            errors++;
            $display("FAIL frame_pulses: got frame_err=%0d new_frame=%0d, expected 0 1", fe_cnt - fe0, nf_cnt - nf0);
        end
    endtask

    task automatic test_green();
        int base, fe0;
        base = px_n; fe0 = fe_cnt;
        special_x = 2; special_y = 1;
        for (int r = 0; r < V; r++) send_line(2 * H, r);
        vsync_pulse();
        checks++;
        if (px_n - base != 12 || fe_cnt != fe0) begin
            errors++;
            $display("FAIL green_frame: got pixels=%0d frame_err=%0d, expected 12 0", px_n - base, fe_cnt - fe0);
        end
        check_frame_pixels("green", base);
        special_x = -1; special_y = -1;
    endtask

    task automatic test_odd_line();
        int base, fe0;
        base = px_n; fe0 = fe_cnt;
        send_line(5, 0);
        send_line(2 * H, 1);
        send_line(2 * H, 2);
        vsync_pulse();
        checks++;
        if (px_n - base != 10 || fe_cnt != fe0 + 1) begin
            errors++;
            $display("FAIL odd_line: got pixels=%0d frame_err=%0d, expected 10 1", px_n - base, fe_cnt - fe0);
        end
        checks++;
        if (px_x[base+1] !== 16'd1 || px_x[base+2] !== 16'd0 || px_y[base+2] !== 16'd1) begin
            errors++;
            $display("FAIL odd_line_pos: got x1=%0d x2=%0d y2=%0d, expected 1 0 1",
                     px_x[base+1], px_x[base+2], px_y[base+2]);
        end
    endtask

    task automatic test_long_line();
        int base, fe0;
        base = px_n; fe0 = fe_cnt;
        send_line(12, 0);
        send_line(2 * H, 1);
        send_line(2 * H, 2);
        vsync_pulse();
        checks++;
        if (px_n - base != 12 || fe_cnt != fe0 + 1) begin
            errors++;
            $display("FAIL long_line: got pixels=%0d frame_err=%0d, expected 12 1", px_n - base, fe_cnt - fe0);
        end
        checks++;
        if (px_x[base+3] !== 16'd3 || px_y[base+3] !== 16'd0 || px_x[base+4] !== 16'd0 || px_y[base+4] !== 16'd1) begin
            errors++;
            $display("FAIL long_line_pos: got (%0d,%0d) (%0d,%0d), expected (3,0) (0,1)",
                     px_x[base+3], px_y[base+3], px_x[base+4], px_y[base+4]);
        end
    endtask

    task automatic test_vsync_abort();
        int base, nf0, fe0, b0;
        logic [15:0] p;
        base = px_n; nf0 = nf_cnt; fe0 = fe_cnt; b0 = both_cnt;
        send_line(2 * H, 0);
        for (int i = 0; i < 4; i++) begin
            p = base_pix;
            @(negedge clk);
            cam_href = 1'b1;
            cam_data = (i % 2 == 0) ? p[15:8] : p[7:0];
        end
        @(negedge clk);
        cam_vsync = 1'b1;
        cam_data  = base_pix[15:8];
        @(negedge clk);
        cam_data  = base_pix[7:0];
        @(negedge clk);
        cam_href  = 1'b0;
        repeat (3) @(negedge clk);
        cam_vsync = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (both_cnt != b0 + 1 || nf_cnt != nf0 + 1 || fe_cnt != fe0 + 1) begin
            errors++;
            $display("FAIL abort_pulses: got same_cycle=%0d new_frame=%0d frame_err=%0d, expected 1 1 1",
                     both_cnt - b0, nf_cnt - nf0, fe_cnt - fe0);
        end
        checks++;
        if (px_n - base != 6) begin
            errors++;
            $display("FAIL abort_pixels: got %0d pixels, expected 6", px_n - base);
        end
        send_line(2 * H, 0);
        checks++;
        if (px_n - base != 10 || px_x[base+6] !== 16'd0 || px_y[base+6] !== 16'd0 || px_x[base+9] !== 16'd3) begin
            errors++;
            $display("FAIL abort_next_frame: got pixels=%0d first=(%0d,%0d) last_x=%0d, expected 10 (0,0) 3",
                     px_n - base, px_x[base+6], px_y[base+6], px_x[base+9]);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_green();
        test_odd_line();
        test_long_line();
        test_vsync_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
